// File: rtl/ram_program_loader_pkg.sv
// ----------------------------------------------------------------------------
// ram_program_loader_pkg
// Shared definitions for the program RAM loader:
//   - default RAM geometry (address width, word width, load length)
//   - loader FSM state encoding (3-bit)
// Imported by ram_program_loader and sap_checksum8.
// ----------------------------------------------------------------------------
package ram_program_loader_pkg;

    localparam int DEFAULT_ADDR_W   = 4;
    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_LOAD_LEN = 16;

    // S_CHECK is only reachable when RAM_LOADER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } loaderState_t;

endpackage

// File: rtl/ram_program_loader_checksum.sv
// ----------------------------------------------------------------------------
// sap_checksum8
// Running mod-2**W sum of the program bytes, used to validate a trailing
// checksum byte.
// Ports:
//   clk_i     clock, rising edge
//   clr_i     asynchronous active-high reset (sum -> 0)
//   clear_i   restart the sum at 0 (start of a new load)
//   add_i     accumulate data_i into the sum this cycle
//   data_i    byte to accumulate
//   cmp_i     checksum byte to compare against the current sum
//   match_o   1 when the accumulated sum equals cmp_i
// ----------------------------------------------------------------------------
module sap_checksum8
    import ram_program_loader_pkg::*;
#(
    parameter int W = DEFAULT_DATA_W
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         clear_i,
    input  logic         add_i,
    input  logic [W-1:0] data_i,
    input  logic [W-1:0] cmp_i,
    output logic         match_o
);

    logic [W-1:0] sum_q;
    logic [W-1:0] sum_d;

    // Clear wins over add so a new load always starts from a clean sum.
    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign match_o = (sum_q == cmp_i);

endmodule

// File: rtl/ram_program_loader.sv
// ----------------------------------------------------------------------------
// ram_program_loader
// Sequential front end for the program RAM. Accepts a byte stream over
// valid/ready, writes LOAD_LEN bytes to consecutive addresses starting at 0
// (one write strobe per byte, at most one byte per two clocks), then hands
// the RAM over to run mode. All outputs are registered.
//
// Optional feature macro: RAM_LOADER_CHECKSUM_EN
//   When defined, one extra byte is accepted after the last data byte and
//   compared with the mod-256 sum of the data bytes; a mismatch raises error
//   and keeps program_mode at 0. When undefined, error is always 0.
//
// Ports:
//   clk           clock, rising edge
//   clr           asynchronous active-high reset
//   start         begin a load (honoured in IDLE/DONE only)
//   in_data       program byte from source
//   in_valid      in_data valid
//   in_ready      loader accepts in_data this cycle
//   program_mode  to RAM: 0 = program, 1 = run
//   address       to RAM: write address
//   program_data  to RAM: write data
//   write_strobe  to RAM: one-cycle write pulse
//   busy          load in progress
//   done          load finished (sticky until next start/clr)
//   error         checksum mismatch
// ----------------------------------------------------------------------------
module ram_program_loader
    import ram_program_loader_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int LOAD_LEN = DEFAULT_LOAD_LEN
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              program_mode,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] program_data,
    output logic              write_strobe,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LOAD_LEN - 1);

    loaderState_t      state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready_q, ready_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              mode_q, mode_d;
    logic              handshake;

`ifdef RAM_LOADER_CHECKSUM_EN
    logic sumClear;
    logic sumAdd;
    logic sumMatch;

    sap_checksum8 #(
        .W(DATA_W)
    ) uChecksum (
        .clk_i   (clk),
        .clr_i   (clr),
        .clear_i (sumClear),
        .add_i   (sumAdd),
        .data_i  (in_data),
        .cmp_i   (in_data),
        .match_o (sumMatch)
    );
`endif

    // Handshake uses the registered ready, so in_valid seen in the same cycle
    // that start is sampled is never taken; the first byte follows a clock later.
    assign handshake = in_valid & ready_q;

    // Next-state and next-output logic. Every output is a register, so the
    // values computed here appear one clock after the decision is made.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ready_d  = 1'b0;
        strobe_d = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        error_d  = error_q;
        mode_d   = mode_q;
`ifdef RAM_LOADER_CHECKSUM_EN
        sumClear = 1'b0;
        sumAdd   = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    mode_d  = 1'b0;
                    ready_d = 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
                    sumClear = 1'b1;
`endif
                end
            end
            S_LOAD: begin
                ready_d = 1'b1;
                if (handshake) begin
                    data_d   = in_data;
                    addr_d   = count_q;
                    strobe_d = 1'b1;
                    ready_d  = 1'b0;
                    state_d  = S_WRITE;
`ifdef RAM_LOADER_CHECKSUM_EN
                    sumAdd = 1'b1;
`endif
                end
            end
            S_WRITE: begin
                if (count_q == LAST_IDX) begin
`ifdef RAM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
                    ready_d = 1'b1;
`else
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    addr_d  = '0;
                    mode_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q + 1'b1;
                    ready_d = 1'b1;
                    state_d = S_LOAD;
                end
            end
`ifdef RAM_LOADER_CHECKSUM_EN
            // The checksum byte is compared but never written to the RAM.
            S_CHECK: begin
                ready_d = 1'b1;
                if (handshake) begin
                    ready_d = 1'b0;
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    addr_d  = '0;
                    error_d = ~sumMatch;
                    mode_d  = sumMatch;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; clr aborts any load immediately.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            mode_q   <= mode_d;
        end
    end

    assign in_ready     = ready_q;
    assign program_mode = mode_q;
    assign address      = addr_q;
    assign program_data = data_q;
    assign write_strobe = strobe_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule
